// File: rtl/word_write_arbiter_if.sv
// Bundles the core write strobe, the shared RAM write bus and status flags of one arbiter stage.
// Latency: none (wires only).
// Backpressure: WR_PREV is the priority token; CARRY_OUT passes it downstream.
//
// Port summary:
//   WR_PREV, WRITE_REQUEST, CORE_WriteADDR/DATA : driven by core / upstream side (master)
//   RAM_WriteADDR/DATA, RAM_WE                 : shared tri-state RAM bus, driven by arbiter (slave)
//   BUSY, ACK, OVERRUN, ERR, CARRY_OUT         : arbiter status and token out
interface word_write_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              WRITEARBITER_WR_PREV;
   logic              WRITEARBITER_WRITE_REQUEST;
   logic [ADDR_W-1:0] WRITEARBITER_CORE_WriteADDR;
   logic [DATA_W-1:0] WRITEARBITER_CORE_WriteDATA;

   // Nets, not variables: several arbiters share this bus and release it with Z.
   wire  [ADDR_W-1:0] WRITEARBITER_RAM_WriteADDR;
   wire  [DATA_W-1:0] WRITEARBITER_RAM_WriteDATA;
   wire               WRITEARBITER_RAM_WE;

   logic              WRITEARBITER_BUSY;
   logic              WRITEARBITER_ACK;
   logic              WRITEARBITER_OVERRUN;
   logic              WRITEARBITER_ERR;
   logic              WRITEARBITER_CARRY_OUT;

   modport master (
      output WRITEARBITER_WR_PREV, WRITEARBITER_WRITE_REQUEST,
             WRITEARBITER_CORE_WriteADDR, WRITEARBITER_CORE_WriteDATA,
      input  WRITEARBITER_RAM_WriteADDR, WRITEARBITER_RAM_WriteDATA, WRITEARBITER_RAM_WE,
             WRITEARBITER_BUSY, WRITEARBITER_ACK, WRITEARBITER_OVERRUN,
             WRITEARBITER_ERR, WRITEARBITER_CARRY_OUT
   );

   modport slave (
      input  WRITEARBITER_WR_PREV, WRITEARBITER_WRITE_REQUEST,
             WRITEARBITER_CORE_WriteADDR, WRITEARBITER_CORE_WriteDATA,
      output WRITEARBITER_RAM_WriteADDR, WRITEARBITER_RAM_WriteDATA, WRITEARBITER_RAM_WE,
             WRITEARBITER_BUSY, WRITEARBITER_ACK, WRITEARBITER_OVERRUN,
             WRITEARBITER_ERR, WRITEARBITER_CARRY_OUT
   );
endinterface

// File: rtl/word_write_arbiter.sv
// Captures one core write and places it on a shared, token-arbitrated tri-state RAM bus.
// Latency: strobe edge 0 -> WE in cycle after edge 1 -> ACK after edge 2 -> idle after edge 3.
// Backpressure: waits in PEND/WRITE while WR_PREV is low; strobes while busy are dropped and flagged.
//
// Ports: CLK (rising edge), RESET_N (async active-low), bus (word_write_arbiter_if.slave).
// Optional macro WRITEARBITER_TIMEOUT_EN: bounds the token wait to TIMEOUT_CYCLES and pulses ERR
// on abort. Without it the wait is unbounded and ERR is tied low.
module word_write_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   word_write_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              busy_q;
   logic              ack_q;
   logic              overrun_q;
   logic              wr_prev;
   logic              wr_req;
   logic              sel;
   logic              timeout_hit;

   assign wr_prev = bus.WRITEARBITER_WR_PREV;
   assign wr_req  = bus.WRITEARBITER_WRITE_REQUEST;

   // Upstream keeps priority even mid-write: dropping WR_PREV releases the bus immediately.
   assign sel = (state_q == WRITE) && wr_prev;

`ifdef WRITEARBITER_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wait_cnt_q;
   logic       err_q;

   // Abort on the edge that would bring the wait count up to TIMEOUT_CYCLES.
   assign timeout_hit = ((state_q == PEND) || (state_q == WRITE)) && !wr_prev &&
                        (wait_cnt_q == TO_LAST);

   // The count is cumulative across PEND and WRITE; it only restarts on a new capture.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wait_cnt_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if ((state_q == IDLE) && wr_req) begin
            wait_cnt_q <= 8'd0;
         end else if (((state_q == PEND) || (state_q == WRITE)) && !wr_prev) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
         end
      end
   end

   assign bus.WRITEARBITER_ERR = err_q;
`else
   wire [7:0] unused_timeout_cycles = 8'(TIMEOUT_CYCLES);

   assign timeout_hit          = 1'b0;
   assign bus.WRITEARBITER_ERR = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;

         // A strobe outside IDLE never touches the captured word.
         if (wr_req && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (wr_req) begin
                  addr_q  <= bus.WRITEARBITER_CORE_WriteADDR;
                  data_q  <= bus.WRITEARBITER_CORE_WriteDATA;
                  state_q <= PEND;
                  busy_q  <= 1'b1;
               end
            end
            PEND: begin
               if (wr_prev) begin
                  state_q <= WRITE;
               end else if (timeout_hit) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            WRITE: begin
               // The single WE cycle is the one ending at this edge.
               if (wr_prev) begin
                  state_q <= DONE;
                  ack_q   <= 1'b1;
               end else if (timeout_hit) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.WRITEARBITER_RAM_WriteADDR = sel ? addr_q : {ADDR_W{1'bz}};
   assign bus.WRITEARBITER_RAM_WriteDATA = sel ? data_q : {DATA_W{1'bz}};
   assign bus.WRITEARBITER_RAM_WE        = sel ? 1'b1   : 1'bz;

   assign bus.WRITEARBITER_BUSY      = busy_q;
   assign bus.WRITEARBITER_ACK       = ack_q;
   assign bus.WRITEARBITER_OVERRUN   = overrun_q;
   assign bus.WRITEARBITER_CARRY_OUT = wr_prev && ((state_q == IDLE) || (state_q == DONE));

endmodule

// File: tb/tb_word_write_arbiter.sv
// Directed bench for word_write_arbiter with a write scoreboard on the RAM bus.
// Latency: inputs change on the falling edge, outputs sampled 4 ns later.
// Backpressure: WR_PREV is driven directly to stall and release the arbiter.
module tb_word_write_arbiter;

   logic CLK;
   logic RESET_N;

   word_write_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   word_write_arbiter #(
      .ADDR_W(16),
      .DATA_W(8),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   int ack_cnt  = 0;
   int err_cnt  = 0;
   logic [23:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic we_on();
      return (bus.WRITEARBITER_RAM_WE === 1'b1);
   endfunction

   // Scoreboard: every WE cycle must match the oldest outstanding accepted write.
   initial begin
      logic prev_we;
      logic [23:0] exp_w;
      prev_we = 1'b0;
      forever begin
         @(negedge CLK);
         #4;
         if (we_on()) begin
            we_cnt++;
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (sb_q.size() == 0) begin
               check("spurious_we", 32'd1, 32'd0);
            end else begin
               exp_w = sb_q.pop_front();
               check("ram_addr", {16'd0, bus.WRITEARBITER_RAM_WriteADDR}, {16'd0, exp_w[23:8]});
               check("ram_data", {24'd0, bus.WRITEARBITER_RAM_WriteDATA}, {24'd0, exp_w[7:0]});
            end
         end
         if (bus.WRITEARBITER_ACK === 1'b1) begin
            ack_cnt++;
            check("ack_after_we", {31'd0, prev_we}, 32'd1);
         end
         if (bus.WRITEARBITER_ERR === 1'b1) err_cnt++;
         prev_we = we_on();
      end
   end

   task automatic strobe(input logic [15:0] a, input logic [7:0] d);
      bus.WRITEARBITER_WRITE_REQUEST  = 1'b1;
      bus.WRITEARBITER_CORE_WriteADDR = a;
      bus.WRITEARBITER_CORE_WriteDATA = d;
   endtask

   initial begin
      int we0;
      int ack0;
      RESET_N = 1'b0;
      bus.WRITEARBITER_WR_PREV        = 1'b0;
      bus.WRITEARBITER_WRITE_REQUEST  = 1'b0;
      bus.WRITEARBITER_CORE_WriteADDR = '0;
      bus.WRITEARBITER_CORE_WriteDATA = '0;

      // Reset state
      #3;
      check("rst_busy",    {31'd0, bus.WRITEARBITER_BUSY},    32'd0);
      check("rst_ack",     {31'd0, bus.WRITEARBITER_ACK},     32'd0);
      check("rst_overrun", {31'd0, bus.WRITEARBITER_OVERRUN}, 32'd0);
      check("rst_err",     {31'd0, bus.WRITEARBITER_ERR},     32'd0);
      check("rst_we_off",  {31'd0, we_on()},                  32'd0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;

      // Best-case write with the token held high
      @(negedge CLK);
      bus.WRITEARBITER_WR_PREV = 1'b1;
      strobe(16'h1234, 8'hA5);
      sb_q.push_back({16'h1234, 8'hA5});
      #4;
      check("s1_idle_busy",  {31'd0, bus.WRITEARBITER_BUSY},      32'd0);
      check("s1_idle_carry", {31'd0, bus.WRITEARBITER_CARRY_OUT}, 32'd1);
      @(negedge CLK);
      bus.WRITEARBITER_WRITE_REQUEST = 1'b0;
      #4;
      check("s1_pend_busy",  {31'd0, bus.WRITEARBITER_BUSY},      32'd1);
      check("s1_pend_carry", {31'd0, bus.WRITEARBITER_CARRY_OUT}, 32'd0);
      check("s1_pend_we",    {31'd0, we_on()},                    32'd0);
      @(negedge CLK); #4;
      check("s1_write_we",    {31'd0, we_on()},                    32'd1);
      check("s1_write_carry", {31'd0, bus.WRITEARBITER_CARRY_OUT}, 32'd0);
      check("s1_write_ack",   {31'd0, bus.WRITEARBITER_ACK},       32'd0);
      @(negedge CLK); #4;
      check("s1_done_ack",   {31'd0, bus.WRITEARBITER_ACK},       32'd1);
      check("s1_done_carry", {31'd0, bus.WRITEARBITER_CARRY_OUT}, 32'd1);
      check("s1_done_we",    {31'd0, we_on()},                    32'd0);
      check("s1_done_busy",  {31'd0, bus.WRITEARBITER_BUSY},      32'd1);
      @(negedge CLK); #4;
      check("s1_idle2_busy", {31'd0, bus.WRITEARBITER_BUSY}, 32'd0);
      check("s1_idle2_ack",  {31'd0, bus.WRITEARBITER_ACK},  32'd0);
      check("s1_we_count",   we_cnt,  32'd1);
      check("s1_ack_count",  ack_cnt, 32'd1);

      // Token withheld for 10 cycles after the strobe
      @(negedge CLK);
      bus.WRITEARBITER_WR_PREV = 1'b0;
      strobe(16'h00F0, 8'h3C);
      sb_q.push_back({16'h00F0, 8'h3C});
      we0 = we_cnt; ack0 = ack_cnt;
      @(negedge CLK);
      bus.WRITEARBITER_WRITE_REQUEST = 1'b0;
      repeat (10) begin
         #4;
         check("s2_wait_we",   {31'd0, we_on()},               32'd0);
         check("s2_wait_busy", {31'd0, bus.WRITEARBITER_BUSY}, 32'd1);
         @(negedge CLK);
      end
      bus.WRITEARBITER_WR_PREV = 1'b1;
      repeat (4) @(negedge CLK);
      #4;
      check("s2_we_count",  we_cnt - we0,   32'd1);
      check("s2_ack_count", ack_cnt - ack0, 32'd1);
      check("s2_busy_end",  {31'd0, bus.WRITEARBITER_BUSY}, 32'd0);
`ifndef WRITEARBITER_TIMEOUT_EN
      check("s2_no_err", err_cnt, 32'd0);
`endif
      check("s2_overrun_clear", {31'd0, bus.WRITEARBITER_OVERRUN}, 32'd0);

      // Second strobe one cycle after the first is dropped
      @(negedge CLK);
      strobe(16'h1234, 8'hA5);
      sb_q.push_back({16'h1234, 8'hA5});
      we0 = we_cnt;
      @(negedge CLK);
      strobe(16'h4321, 8'h5A);
      @(negedge CLK);
      bus.WRITEARBITER_WRITE_REQUEST = 1'b0;
      #4;
      check("s3_overrun", {31'd0, bus.WRITEARBITER_OVERRUN}, 32'd1);
      repeat (4) @(negedge CLK);
      #4;
      check("s3_we_count", we_cnt - we0, 32'd1);
      check("s3_overrun_sticky", {31'd0, bus.WRITEARBITER_OVERRUN}, 32'd1);

      // Token dropped for 3 cycles while in WRITE
      @(negedge CLK);
      strobe(16'h0BEE, 8'h77);
      sb_q.push_back({16'h0BEE, 8'h77});
      we0 = we_cnt; ack0 = ack_cnt;
      @(negedge CLK);
      bus.WRITEARBITER_WRITE_REQUEST = 1'b0;
      @(negedge CLK);
      bus.WRITEARBITER_WR_PREV = 1'b0;
      repeat (3) begin
         #4;
         check("s4_stall_we",    {31'd0, we_on()},                    32'd0);
         check("s4_stall_carry", {31'd0, bus.WRITEARBITER_CARRY_OUT}, 32'd0);
         check("s4_stall_busy",  {31'd0, bus.WRITEARBITER_BUSY},      32'd1);
         @(negedge CLK);
      end
      bus.WRITEARBITER_WR_PREV = 1'b1;
      #4;
      check("s4_resume_we", {31'd0, we_on()}, 32'd1);
      repeat (4) @(negedge CLK);
      #4;
      check("s4_we_count",  we_cnt - we0,   32'd1);
      check("s4_ack_count", ack_cnt - ack0, 32'd1);

      // Reset while waiting in PEND
      @(negedge CLK);
      bus.WRITEARBITER_WR_PREV = 1'b0;
      strobe(16'hDEAD, 8'h11);
      we0 = we_cnt; ack0 = ack_cnt;
      @(negedge CLK);
      bus.WRITEARBITER_WRITE_REQUEST = 1'b0;
      #2;
      check("s5_pend_busy", {31'd0, bus.WRITEARBITER_BUSY}, 32'd1);
      RESET_N = 1'b0;
      #1;
      check("s5_rst_busy",    {31'd0, bus.WRITEARBITER_BUSY},    32'd0);
      check("s5_rst_overrun", {31'd0, bus.WRITEARBITER_OVERRUN}, 32'd0);
      check("s5_rst_ack",     {31'd0, bus.WRITEARBITER_ACK},     32'd0);
      check("s5_rst_we",      {31'd0, we_on()},                  32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      bus.WRITEARBITER_WR_PREV = 1'b1;
      repeat (5) @(negedge CLK);
      #4;
      check("s5_no_we",  we_cnt - we0,   32'd0);
      check("s5_no_ack", ack_cnt - ack0, 32'd0);

`ifdef WRITEARBITER_TIMEOUT_EN
      // Timeout abort after 4 waiting cycles
      @(negedge CLK);
      bus.WRITEARBITER_WR_PREV = 1'b0;
      strobe(16'h5555, 8'h66);
      we0 = we_cnt; ack0 = ack_cnt;
      @(negedge CLK);
      bus.WRITEARBITER_WRITE_REQUEST = 1'b0;
      repeat (3) @(negedge CLK);
      #4;
      check("s6_err_not_yet", {31'd0, bus.WRITEARBITER_ERR}, 32'd0);
      @(negedge CLK); #4;
      check("s6_err_pulse", {31'd0, bus.WRITEARBITER_ERR},  32'd1);
      check("s6_busy_low",  {31'd0, bus.WRITEARBITER_BUSY}, 32'd0);
      repeat (4) @(negedge CLK);
      #4;
      check("s6_err_count", err_cnt,        32'd1);
      check("s6_no_we",     we_cnt - we0,   32'd0);
      check("s6_no_ack",    ack_cnt - ack0, 32'd0);
`endif

      check("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/word_write_arbiter.md
WORD_WRITE_ARBITER -- requirements
Module: word_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of the core and RAM write buses.
REQ-002 Parameter DATA_W, default 8, data width of the core and RAM write buses.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, grant-wait limit used only with WRITEARBITER_TIMEOUT_EN; legal range 1..255.
REQ-004 Ports SHALL be, one per line, as follows; one clock; reset is asynchronous and active-low:
CLK  input  1  sole clock, rising edge.
RESET_N  input  1  asynchronous active-low reset.
WRITEARBITER_WR_PREV  input  1  write token from the upstream arbiter (carry in).
WRITEARBITER_WRITE_REQUEST  input  1  single-cycle write strobe from the core.
WRITEARBITER_CORE_WriteADDR  input  ADDR_W  core write address, sampled with the strobe.
WRITEARBITER_CORE_WriteDATA  input  DATA_W  core write data, sampled with the strobe.
WRITEARBITER_RAM_WriteADDR  output  ADDR_W  shared RAM address bus, tri-stated when not selected.
WRITEARBITER_RAM_WriteDATA  output  DATA_W  shared RAM data bus, tri-stated when not selected.
WRITEARBITER_RAM_WE  output  1  shared RAM write enable, tri-stated when not selected.
WRITEARBITER_BUSY  output  1  high while a write is held (state other than IDLE).
WRITEARBITER_ACK  output  1  one-cycle write-complete pulse.
WRITEARBITER_OVERRUN  output  1  sticky flag: a strobe arrived while busy.
WRITEARBITER_ERR  output  1  one-cycle timeout-abort pulse.
WRITEARBITER_CARRY_OUT  output  1  token to the downstream arbiter.

Function
REQ-005 The FSM SHALL have states IDLE, PEND, WRITE and DONE, held in registers clocked by CLK.
REQ-006 In IDLE, a strobe SHALL capture the address and data into internal registers and move to PEND on the same edge.
REQ-007 A strobe in any state other than IDLE SHALL be dropped, SHALL set OVERRUN, and SHALL not alter the captured address or data.
REQ-008 PEND SHALL move to WRITE on an edge where WR_PREV is high, and SHALL otherwise hold.
REQ-009 Selection SHALL equal (state==WRITE && WR_PREV); while selected, the RAM buses SHALL drive the captured address and data and RAM_WE SHALL be 1.
REQ-010 While not selected, RAM_WriteADDR, RAM_WriteDATA and RAM_WE SHALL all be high-impedance.
REQ-011 WRITE SHALL move to DONE on an edge where WR_PREV is high, so the RAM sees exactly one WE cycle.
REQ-012 If WR_PREV is low in WRITE, the block SHALL stall in WRITE with the buses tri-stated, because upstream has priority.
REQ-013 DONE SHALL assert ACK for exactly one cycle and SHALL return to IDLE on the next edge.
REQ-014 CARRY_OUT SHALL equal WR_PREV && (state==IDLE || state==DONE); it is combinational, and the token is held in PEND and WRITE.
REQ-015 Best-case latency: strobe sampled at edge 0, WE high in the cycle after edge 1, ACK high in the cycle after edge 2, BUSY low after edge 3.
REQ-016 BUSY SHALL equal (state != IDLE).

Reset
REQ-017 While RESET_N is low, the state SHALL be IDLE, BUSY, ACK, OVERRUN and ERR SHALL be 0, the captured registers SHALL be 0, and the RAM buses SHALL be high-impedance.
REQ-018 Reset mid-operation SHALL abort any pending write without asserting WE or ACK.
REQ-019 OVERRUN SHALL clear only on reset.

Configuration
REQ-020 With WRITEARBITER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to PEND and increment on every PEND or WRITE cycle with WR_PREV low.
REQ-021 With WRITEARBITER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the FSM SHALL go to IDLE, pulse ERR for one cycle, and issue no WE and no ACK.
REQ-022 Without WRITEARBITER_TIMEOUT_EN, no counter SHALL exist, ERR SHALL be tied to 0, waiting SHALL be unbounded, and TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-023 WR_PREV held 1, strobe with ADDR=0x1234 and DATA=0xA5 -> exactly one WE cycle on 0x1234/0xA5, ACK one cycle later, CARRY_OUT 0 only in PEND and WRITE.
REQ-024 WR_PREV held 0 for 10 cycles after a strobe, then 1 -> buses stay Z throughout the wait, then one write, then ACK; ERR stays 0 when built without the macro.
REQ-025 Second strobe (DATA=0x5A) one cycle after the first -> OVERRUN=1, RAM receives only the first data 0xA5.
REQ-026 WR_PREV dropped for 3 cycles while in WRITE -> WE and buses stay Z for 3 cycles, then a single write, no duplicate.
REQ-027 Built with WRITEARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, WR_PREV held 0 -> ERR pulses after 4 waiting cycles, no WE, no ACK, BUSY returns to 0.
REQ-028 RESET_N asserted in PEND -> all outputs at reset values immediately; after release, no WE or ACK.
